// File: rtl/alu_cmd_driver.sv
// Command driver for the 8-bit ALU: packs commands into the ALU instruction word,
// waits out the ALU latency, then holds the captured result until the consumer accepts it.
module alu_cmd_driver #(
    parameter int ALU_LATENCY = 1,
    parameter int MAX_OP      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic [19:0] alu_in,
    input  logic [15:0] alu_out,
    input  logic [7:0]  alu_flag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_op,
    output logic [15:0] rsp_out,
    output logic [7:0]  rsp_flag,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] op_count
);

    localparam int CW = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          illegal;

    // Opcodes past MAX_OP and divide-by-zero never reach the ALU.
    assign illegal = (int'(cmd_op) > MAX_OP) || (cmd_op == 4'd4 && cmd_b == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            alu_in    <= '0;
            rsp_valid <= 1'b0;
            rsp_op    <= '0;
            rsp_out   <= '0;
            rsp_flag  <= '0;
            rsp_err   <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rsp_op    <= cmd_op;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (illegal) begin
                            rsp_err   <= 1'b1;
                            rsp_out   <= '0;
                            rsp_flag  <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_in <= {cmd_op, cmd_a, cmd_b};
                            count  <= CW'(ALU_LATENCY);
                            state  <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        rsp_out   <= alu_out;
                        rsp_flag  <= alu_flag;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // cmd_ready returns one edge after the handshake, so no back-to-back accept.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: directed vector table, stall/reset/wrap
// sequences, and randomized commands against an arithmetic reference model.
module tb_alu_cmd_driver;

    localparam int ALU_LATENCY = 1;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [19:0] alu_in;
    logic [15:0] alu_out;
    logic [7:0]  alu_flag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_op;
    logic [15:0] rsp_out;
    logic [7:0]  rsp_flag;
    logic        rsp_err;
    logic        busy;
    logic [15:0] op_count;

    int          assertCount;
    int          failCount;
    logic [19:0] expAluIn;
    logic [15:0] expCount;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        int          hold;
        logic [15:0] expOut;
        logic [7:0]  expFlag;
        logic        expErr;
    } vec_t;

    vec_t vecs[12];

    alu_cmd_driver #(.ALU_LATENCY(ALU_LATENCY), .MAX_OP(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_in    (alu_in),
        .alu_out   (alu_out),
        .alu_flag  (alu_flag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_op    (rsp_op),
        .rsp_out   (rsp_out),
        .rsp_flag  (rsp_flag),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU decoding the packed word; flags carry the opcode it saw.
    always_comb begin
        logic [15:0] ea;
        logic [15:0] eb;
        ea = {8'h00, alu_in[15:8]};
        eb = {8'h00, alu_in[7:0]};
        case (alu_in[19:16])
            4'd0:    alu_out = 16'h0000 - ea;
            4'd1:    alu_out = ea + eb;
            4'd2:    alu_out = ea - eb;
            4'd3:    alu_out = ea * eb;
            4'd4:    alu_out = (eb != 16'h0) ? ea / eb : 16'hFFFF;
            4'd5:    alu_out = ea & eb;
            4'd6:    alu_out = ea | eb;
            4'd7:    alu_out = ea ^ eb;
            default: alu_out = 16'hDEAD;
        endcase
        alu_flag = {4'hA, alu_in[19:16]};
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic void refModel(input int op, input int a, input int b,
                                     output logic [15:0] r, output logic [7:0] f, output logic e);
        int v;
        v = 0;
        e = (op > 7) || (op == 4 && b == 0);
        case (op)
            0: v = -a;
            1: v = a + b;
            2: v = a - b;
            3: v = a * b;
            4: v = (b != 0) ? a / b : 0;
            5: v = a & b;
            6: v = a | b;
            7: v = a ^ b;
            default: v = 0;
        endcase
        r = e ? 16'h0 : 16'(v & 32'hFFFF);
        f = e ? 8'h0 : 8'(32'hA0 + op);
    endfunction

    // One full command/response transaction; inputs driven #1 after a rising edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input int hold, input logic [15:0] expOut,
                                 input logic [7:0] expFlag, input logic expErr);
        int          waitCycles;
        int          lat;
        logic        stableOk;
        logic [3:0]  snapOp;
        logic [15:0] snapOut;
        logic [7:0]  snapFlag;
        logic        snapErr;
        waitCycles = 0;
        while (!cmd_ready && waitCycles < 50) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        checkOutput("cmd_ready before issue", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk); #1;
        // Junk stays offered while busy; the driver must ignore it.
        cmd_op = 4'($urandom);
        cmd_a  = 8'($urandom);
        cmd_b  = 8'($urandom);
        checkOutput("busy after accept", 32'(busy), 32'd1);
        checkOutput("cmd_ready after accept", 32'(cmd_ready), 32'd0);
        if (!expErr) expAluIn = {op, a, b};
        checkOutput("alu_in after accept", 32'(alu_in), 32'(expAluIn));
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("rsp latency", 32'(lat), expErr ? 32'd0 : 32'(ALU_LATENCY));
        checkOutput("rsp_op", 32'(rsp_op), 32'(op));
        checkOutput("rsp_out", 32'(rsp_out), 32'(expOut));
        checkOutput("rsp_flag", 32'(rsp_flag), 32'(expFlag));
        checkOutput("rsp_err", 32'(rsp_err), 32'(expErr));
        checkOutput("cmd_ready in resp", 32'(cmd_ready), 32'd0);
        snapOp   = rsp_op;
        snapOut  = rsp_out;
        snapFlag = rsp_flag;
        snapErr  = rsp_err;
        stableOk = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!rsp_valid || cmd_ready || rsp_op != snapOp || rsp_out != snapOut ||
                rsp_flag != snapFlag || rsp_err != snapErr)
                stableOk = 1'b0;
        end
        if (hold > 0) checkOutput("rsp stable while stalled", 32'(stableOk), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        expCount  = expCount + 16'd1;
        checkOutput("rsp_valid after handshake", 32'(rsp_valid), 32'd0);
        checkOutput("op_count", 32'(op_count), 32'(expCount));
        checkOutput("busy after handshake", 32'(busy), 32'd0);
        checkOutput("cmd_ready after handshake", 32'(cmd_ready), 32'd1);
        checkOutput("alu_in held", 32'(alu_in), 32'(expAluIn));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] r;
        logic [7:0]  f;
        logic        e;
        logic [3:0]  rop;
        logic [7:0]  ra;
        logic [7:0]  rb;
        int          waitCycles;

        assertCount = 0;
        failCount   = 0;
        expAluIn    = '0;
        expCount    = '0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_a       = '0;
        cmd_b       = '0;
        rsp_ready   = 1'b0;

        vecs[0]  = '{4'd1, 8'h32, 8'h2D, 0, 16'h005F, 8'hA1, 1'b0};
        vecs[1]  = '{4'd3, 8'h32, 8'h2D, 5, 16'h08CA, 8'hA3, 1'b0};
        vecs[2]  = '{4'd4, 8'h32, 8'h00, 0, 16'h0000, 8'h00, 1'b1};
        vecs[3]  = '{4'd9, 8'h32, 8'h2D, 0, 16'h0000, 8'h00, 1'b1};
        vecs[4]  = '{4'd0, 8'h32, 8'h2D, 0, 16'hFFCE, 8'hA0, 1'b0};
        vecs[5]  = '{4'd1, 8'h32, 8'h2D, 0, 16'h005F, 8'hA1, 1'b0};
        vecs[6]  = '{4'd2, 8'h32, 8'h2D, 0, 16'h0005, 8'hA2, 1'b0};
        vecs[7]  = '{4'd3, 8'h32, 8'h2D, 0, 16'h08CA, 8'hA3, 1'b0};
        vecs[8]  = '{4'd4, 8'h32, 8'h2D, 0, 16'h0001, 8'hA4, 1'b0};
        vecs[9]  = '{4'd5, 8'h32, 8'h2D, 0, 16'h0020, 8'hA5, 1'b0};
        vecs[10] = '{4'd6, 8'h32, 8'h2D, 0, 16'h003F, 8'hA6, 1'b0};
        vecs[11] = '{4'd7, 8'h32, 8'h2D, 0, 16'h001F, 8'hA7, 1'b0};

        #12;
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset alu_in", 32'(alu_in), 32'd0);
        checkOutput("reset op_count", 32'(op_count), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset rsp_out", 32'(rsp_out), 32'd0);
        checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed vector table");
        foreach (vecs[i])
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold,
                          vecs[i].expOut, vecs[i].expFlag, vecs[i].expErr);

        $display("[TB] randomized commands");
        for (int n = 0; n < 150; n++) begin
            rop = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) rop = 4'hF;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            refModel(int'(rop), int'(ra), int'(rb), r, f, e);
            applyStimulus(rop, ra, rb, int'($urandom_range(0, 3)), r, f, e);
        end

        $display("[TB] op_count wrap");
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        expCount = 16'hFFFF;
        applyStimulus(4'd1, 8'h01, 8'h02, 0, 16'h0003, 8'hA1, 1'b0);
        applyStimulus(4'd2, 8'h05, 8'h02, 0, 16'h0003, 8'hA2, 1'b0);

        $display("[TB] reset during WAIT");
        cmd_valid = 1'b1;
        cmd_op    = 4'd3;
        cmd_a     = 8'h11;
        cmd_b     = 8'h22;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("wait-reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("wait-reset alu_in", 32'(alu_in), 32'd0);
        checkOutput("wait-reset op_count", 32'(op_count), 32'd0);
        checkOutput("wait-reset cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("wait-reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expCount = '0;
        expAluIn = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("wait-reset no late rsp", 32'(rsp_valid), 32'd0);

        $display("[TB] reset during RESP");
        applyStimulus(4'd5, 8'hF0, 8'h3C, 0, 16'h0030, 8'hA5, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 4'd1;
        cmd_a     = 8'h10;
        cmd_b     = 8'h20;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        waitCycles = 0;
        while (!rsp_valid && waitCycles < 20) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        checkOutput("resp-reset reached RESP", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("resp-reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("resp-reset op_count", 32'(op_count), 32'd0);
        checkOutput("resp-reset rsp_out", 32'(rsp_out), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkOutput("resp-reset count not bumped", 32'(op_count), 32'd0);
        expCount = '0;
        expAluIn = '0;
        applyStimulus(4'd6, 8'h0F, 8'hF0, 2, 16'h00FF, 8'hA6, 1'b0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
